// File: rtl/dft_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dft_ctrl_pkg
// Shared types and default sizing for the DFT streaming controller.
//   dft_state_e      : controller state encoding (IDLE, LOAD, WAIT, UNLOAD)
//   DFT_NWORDS_DEF   : default words per transform
//   DFT_AW_DEF       : default buffer address width (log2 of words)
//   DFT_TMO_CYC_DEF  : default WAIT-state timeout in cycles (16-bit range)
// -----------------------------------------------------------------------------
package dft_ctrl_pkg;

    localparam int DFT_NWORDS_DEF  = 32;
    localparam int DFT_AW_DEF      = 5;
    localparam int DFT_TMO_CYC_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UNLOAD = 2'd3
    } dft_state_e;

endpackage

// File: rtl/dft_ctrl_wdog.sv
// -----------------------------------------------------------------------------
// dft_ctrl_wdog
// Watchdog for the WAIT state of the DFT streaming controller. Counts cycles
// while enabled; flags expiry in the TMO_CYC-th enabled cycle since the last
// clear.
// Ports:
//   wb_clk_i  : clock (rising edge)
//   wb_rst_i  : asynchronous active-high reset
//   enable    : count this cycle
//   clear     : restart the count (wins over enable)
//   expired   : high in the cycle the limit is reached
// -----------------------------------------------------------------------------
module dft_ctrl_wdog #(
    parameter int TMO_CYC = 1024
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    // Counter runs 0..TMO_CYC-1, so the N-th enabled cycle sees count N-1.
    localparam logic [15:0] LIMIT = 16'(TMO_CYC - 1);

    logic [15:0] cnt_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign expired = enable && !clear && (cnt_q == LIMIT);

endmodule

// File: rtl/dft_stream_ctrl.sv
// -----------------------------------------------------------------------------
// dft_stream_ctrl
// Sequences one DFT transform: streams NWORDS words from the input buffer into
// the core, waits for the core's output frame, then writes NWORDS words into
// the output buffer.
// Optional build macro: DFT_STREAM_CTRL_TIMEOUT_EN -- when defined, WAIT gives
// up after TMO_CYC cycles (err_o set, no done_o). When undefined WAIT waits
// indefinitely and no watchdog is built.
// Ports:
//   wb_clk_i, wb_rst_i       : clock, asynchronous active-high reset
//   start_i, abort_i         : run request / cancel
//   busy_o, done_o, err_o    : run status, completion pulse, sticky error
//   in_rd_en_o/in_rd_addr_o  : input-buffer read port
//   core_next_o              : frame-start pulse to the core
//   core_next_out_i          : output-frame-start pulse from the core
//   out_wr_en_o/out_wr_addr_o: output-buffer write port
//   data_valid_o             : output buffer holds a complete result
// -----------------------------------------------------------------------------
module dft_stream_ctrl
    import dft_ctrl_pkg::*;
#(
    parameter int NWORDS  = DFT_NWORDS_DEF,
    parameter int AW      = DFT_AW_DEF,
    parameter int TMO_CYC = DFT_TMO_CYC_DEF
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          in_rd_en_o,
    output logic [AW-1:0] in_rd_addr_o,
    output logic          core_next_o,
    input  logic          core_next_out_i,
    output logic          out_wr_en_o,
    output logic [AW-1:0] out_wr_addr_o,
    output logic          data_valid_o
);

    // Elaboration-time sanity checks on the configuration.
    if (NWORDS != (1 << AW)) begin : g_bad_size
        $error("dft_stream_ctrl: NWORDS must equal 2**AW");
    end
    if ((TMO_CYC < 1) || (TMO_CYC > 65535)) begin : g_bad_tmo
        $error("dft_stream_ctrl: TMO_CYC must fit in 16 bits and be nonzero");
    end

    localparam logic [AW-1:0] LAST_WORD = AW'(NWORDS - 1);

    dft_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          dv_q, dv_d;
    logic          done_q, done_d;
    logic          tmo_expired;

`ifdef DFT_STREAM_CTRL_TIMEOUT_EN
    dft_ctrl_wdog #(
        .TMO_CYC (TMO_CYC)
    ) u_wdog (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .enable   (state_q == ST_WAIT),
        .clear    (state_q != ST_WAIT),
        .expired  (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
        end
    end

    // The word counter returns to 0 whenever it is not advancing, so every
    // LOAD and UNLOAD phase starts at address 0 and never passes LAST_WORD.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        err_d   = err_q;
        dv_d    = dv_q;
        done_d  = 1'b0;

        if (abort_i) begin
            // Abort outranks start and the core's frame pulse.
            state_d = ST_IDLE;
            dv_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_LOAD;
                        err_d   = 1'b0;
                        dv_d    = 1'b0;
                    end
                end
                ST_LOAD: begin
                    // An output frame before the input frame is complete
                    // means the core and controller are out of step.
                    if (core_next_out_i) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else if (cnt_q == LAST_WORD) begin
                        state_d = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (core_next_out_i) begin
                        state_d = ST_UNLOAD;
                    end else if (tmo_expired) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (cnt_q == LAST_WORD) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        dv_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from registered state so reset clears them
    // without waiting for a clock edge.
    assign busy_o        = (state_q != ST_IDLE);
    assign in_rd_en_o    = (state_q == ST_LOAD);
    assign in_rd_addr_o  = (state_q == ST_LOAD) ? cnt_q : '0;
    assign core_next_o   = (state_q == ST_LOAD) && (cnt_q == '0);
    assign out_wr_en_o   = (state_q == ST_UNLOAD);
    assign out_wr_addr_o = (state_q == ST_UNLOAD) ? cnt_q : '0;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign data_valid_o  = dv_q;

endmodule

// File: tb/tb_dft_stream_ctrl.sv
module tb_dft_stream_ctrl;

    localparam int NW  = 32;
    localparam int AW  = 5;
    localparam int TMO = 16;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          core_next_out_i = 1'b0;
    logic          busy_o, done_o, err_o, in_rd_en_o, core_next_o;
    logic          out_wr_en_o, data_valid_o;
    logic [AW-1:0] in_rd_addr_o, out_wr_addr_o;

    dft_stream_ctrl #(.NWORDS(NW), .AW(AW), .TMO_CYC(TMO)) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .in_rd_en_o      (in_rd_en_o),
        .in_rd_addr_o    (in_rd_addr_o),
        .core_next_o     (core_next_o),
        .core_next_out_i (core_next_out_i),
        .out_wr_en_o     (out_wr_en_o),
        .out_wr_addr_o   (out_wr_addr_o),
        .data_valid_o    (data_valid_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int cyc = 0;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    // Scoreboard records
    typedef struct {
        int cyc;
        bit rd;
        int rd_addr;
        bit cn;
        bit wr;
        int wr_addr;
        bit done;
    } strobe_t;

    typedef struct {
        int cyc;
        bit busy;
        bit err;
        bit dv;
    } status_t;

    strobe_t strobe_q[$];
    status_t status_q[$];

    // Reference model: a run is a schedule. Each phase remembers the cycle it
    // began; strobes and addresses follow from the offset into the phase.
    typedef enum int { M_IDLE, M_LOAD, M_WAIT, M_UNLOAD } mode_t;
    mode_t m_mode = M_IDLE;
    int    m_base = 0;
    bit    m_err = 0;
    bit    m_dv = 0;
    int    m_done_at = -1;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_base = 0;
        m_err = 0;
        m_dv = 0;
        m_done_at = -1;
    endtask

    task automatic model_step(input bit s, input bit a, input bit c);
        strobe_t e;
        status_t st;
        int t, off;
        t = cyc;
        off = t - m_base;
        e.cyc = t;
        e.rd = (m_mode == M_LOAD);
        e.rd_addr = e.rd ? off : 0;
        e.cn = e.rd && (off == 0);
        e.wr = (m_mode == M_UNLOAD);
        e.wr_addr = e.wr ? off : 0;
        e.done = (t == m_done_at);
        if (e.rd || e.wr || e.cn || e.done) strobe_q.push_back(e);
        st.cyc = t;
        st.busy = (m_mode != M_IDLE);
        st.err = m_err;
        st.dv = m_dv;
        status_q.push_back(st);

        if (a) begin
            m_mode = M_IDLE;
            m_dv = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (s) begin
                    m_mode = M_LOAD; m_base = t + 1; m_err = 0; m_dv = 0;
                end
                M_LOAD: begin
                    if (c) begin
                        m_mode = M_IDLE; m_err = 1;
                    end else if (off == NW - 1) begin
                        m_mode = M_WAIT; m_base = t + 1;
                    end
                end
                M_WAIT: begin
                    if (c) begin
                        m_mode = M_UNLOAD; m_base = t + 1;
                    end
`ifdef DFT_STREAM_CTRL_TIMEOUT_EN
                    else if (off + 1 == TMO) begin
                        m_mode = M_IDLE; m_err = 1;
                    end
`endif
                end
                M_UNLOAD: if (off == NW - 1) begin
                    m_mode = M_IDLE; m_done_at = t + 1; m_dv = 1;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    // Monitor: samples on the falling edge, pops expectations.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (status_q.size() == 0) begin
                chk("status_underflow", 1, 0);
            end else begin
                status_t st;
                st = status_q.pop_front();
                chk("status_cycle", cyc, st.cyc);
                chk("busy", busy_o, st.busy);
                chk("err", err_o, st.err);
                chk("data_valid", data_valid_o, st.dv);
            end
            if (in_rd_en_o || out_wr_en_o || core_next_o || done_o) begin
                if (strobe_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    strobe_t e;
                    e = strobe_q.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("in_rd_en", in_rd_en_o, e.rd);
                    chk("in_rd_addr", int'(in_rd_addr_o), e.rd_addr);
                    chk("core_next", core_next_o, e.cn);
                    chk("out_wr_en", out_wr_en_o, e.wr);
                    chk("out_wr_addr", int'(out_wr_addr_o), e.wr_addr);
                    chk("done", done_o, e.done);
                end
            end else begin
                chk("idle_addr", int'({in_rd_addr_o, out_wr_addr_o}), 0);
            end
        end
    end

    task automatic step(input bit s, input bit a, input bit c);
        @(posedge wb_clk_i);
        #1;
        start_i = s;
        abort_i = a;
        core_next_out_i = c;
        model_step(s, a, c);
    endtask

    task automatic do_reset(input int n, input bit s);
        @(posedge wb_clk_i);
        #1;
        start_i = 0;
        abort_i = 0;
        core_next_out_i = 0;
        wb_rst_i = 1;
        #1;
        chk("async_reset_outputs",
            int'({busy_o, done_o, err_o, in_rd_en_o, in_rd_addr_o, core_next_o,
                  out_wr_en_o, out_wr_addr_o, data_valid_o}), 0);
        strobe_q.delete();
        status_q.delete();
        repeat (n) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 0;
        start_i = s;
        model_reset();
        model_step(s, 0, 0);
    endtask

    initial begin
        // Reset, then the nominal run with the core frame 40 cycles in.
        do_reset(3, 1'b1);
        for (int r = 1; r <= 75; r++) step(0, 0, r == 40);

        // Repeated starts while busy are ignored.
        for (int r = 0; r <= 80; r++) step(r == 0 || r == 5 || r == 50, 0, r == 40);

        // Abort during LOAD.
        for (int r = 0; r <= 40; r++) step(r == 0, r == 10, 0);

        // Core frame during LOAD is an error; next start clears it.
        for (int r = 0; r <= 25; r++) step(r == 0, 0, r == 20);
        for (int r = 0; r <= 80; r++) step(r == 0, 0, r == 40);

        // Core frame pulse in IDLE is ignored; abort wins over start.
        step(0, 0, 1);
        step(1, 1, 0);
        step(0, 0, 0);

        // No core frame: timeout when built in, otherwise stays busy.
`ifdef DFT_STREAM_CTRL_TIMEOUT_EN
        for (int r = 0; r <= 60; r++) step(r == 0, 0, 0);
`else
        for (int r = 0; r <= 2040; r++) step(r == 0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
`endif

        // Asynchronous reset mid-UNLOAD, start in the release cycle.
        for (int r = 0; r <= 50; r++) step(r == 0, 0, r == 40);
        do_reset(2, 1'b1);
        for (int r = 1; r <= 80; r++) step(0, 0, r == 40);

        // Randomized traffic.
        for (int r = 0; r < 3000; r++) begin
            step(($urandom % 8) == 0, ($urandom % 97) == 0, ($urandom % 24) == 0);
        end
        for (int r = 0; r < 4; r++) step(0, 1, 0);
        step(0, 0, 0);

        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1;
        #1;
        chk("strobes_left", strobe_q.size(), 0);
        chk("status_left", status_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dft_stream_ctrl.md
DFT_STREAM_CTRL -- requirements
Module: dft_stream_ctrl

Interface
REQ-001 SHALL have parameter NWORDS, default 32, words per transform (power of two, 2..64).
REQ-002 SHALL have parameter AW, default 5, buffer address width equal to log2(NWORDS).
REQ-003 SHALL have parameter TMO_CYC, default 1024, maximum WAIT-state cycles before timeout (16-bit).
REQ-004 SHALL have the following ports, clock and reset first:
  wb_clk_i  in  1  sole clock; all logic on the rising edge.
  wb_rst_i  in  1  reset, asynchronous and active-high.
  start_i  in  1  single-cycle request to run one transform.
  abort_i  in  1  cancels any run in progress.
  busy_o  out  1  high from acceptance of start until return to IDLE.
  done_o  out  1  single-cycle pulse when the last output word has been written.
  err_o  out  1  sticky error flag; cleared by an accepted start_i.
  in_rd_en_o  out  1  input-buffer read strobe.
  in_rd_addr_o  out  AW  input-buffer read address.
  core_next_o  out  1  single-cycle frame-start pulse to the DFT core.
  core_next_out_i  in  1  single-cycle output-frame-start pulse from the DFT core.
  out_wr_en_o  out  1  output-buffer write strobe.
  out_wr_addr_o  out  AW  output-buffer write address.
  data_valid_o  out  1  output buffer holds a complete result.

Function
REQ-005 SHALL implement states IDLE, LOAD, WAIT, UNLOAD.
REQ-006 IDLE: start_i=1 SHALL move to LOAD next cycle, raise busy_o, clear err_o and data_valid_o.
REQ-007 SHALL assert core_next_o for exactly the first LOAD cycle (cycle T).
REQ-008 SHALL assert in_rd_en_o in cycles T..T+NWORDS-1, with in_rd_addr_o = k in cycle T+k (one-cycle buffer latency places word k at the core in cycle T+k+1).
REQ-009 After address NWORDS-1, SHALL enter WAIT; the word counter wraps to 0, never exceeds NWORDS-1.
REQ-010 WAIT: core_next_out_i=1 in cycle U SHALL move to UNLOAD.
REQ-011 SHALL assert out_wr_en_o in cycles U+1..U+NWORDS with out_wr_addr_o = k in cycle U+1+k.
REQ-012 SHALL pulse done_o, set data_valid_o, and return to IDLE in the cycle after the last write (U+NWORDS+1).
REQ-013 start_i while busy_o=1 SHALL be ignored with no side effect.
REQ-014 core_next_out_i in LOAD SHALL set err_o and return to IDLE; in UNLOAD or IDLE it SHALL be ignored.
REQ-015 abort_i SHALL, from any state, return to IDLE next cycle, deassert all strobes, leave data_valid_o 0, and not pulse done_o; abort_i has priority over start_i and core_next_out_i in the same cycle.
REQ-016 in_rd_en_o, out_wr_en_o and core_next_o SHALL never be high outside the cycles given above.

Reset
REQ-017 wb_rst_i SHALL asynchronously force IDLE and all outputs to 0 (addresses 0), including mid-run; the first start_i is accepted on the first clock edge after release.

Configuration
REQ-018 With DFT_STREAM_CTRL_TIMEOUT_EN defined, WAIT SHALL count cycles; on reaching TMO_CYC without core_next_out_i, it SHALL set err_o and return to IDLE with no done_o.
REQ-019 Without DFT_STREAM_CTRL_TIMEOUT_EN, WAIT SHALL wait indefinitely, TMO_CYC is unused, and no timeout counter is synthesized.

Structure
REQ-020 Package dft_ctrl_pkg SHALL hold the state enum type and the defaults for NWORDS, AW and TMO_CYC.
REQ-021 The timeout counter SHALL be a sub-module dft_ctrl_wdog (inputs: enable, clear; output: expired), instantiated only under the macro.

Verification
REQ-022 Reset, start_i at cycle 0, core_next_out_i at cycle 40 -> core_next_o at cycle 1; reads addr 0..31 at cycles 1..32; writes addr 0..31 at cycles 41..72; done_o at cycle 73; data_valid_o=1.
REQ-023 Run as in REQ-022 with start_i repeated at cycles 5 and 50 -> identical waveform, no second run.
REQ-024 abort_i at cycle 10 of a run -> IDLE at cycle 11; no strobes thereafter; done_o=0; data_valid_o=0.
REQ-025 core_next_out_i at cycle 20, during LOAD -> err_o=1, IDLE next cycle; the next start_i clears err_o.
REQ-026 With the macro defined and TMO_CYC=16, no core_next_out_i -> err_o=1 after 16 WAIT cycles, busy_o=0; without the macro, busy_o stays 1 for 2000 cycles.
REQ-027 wb_rst_i asserted asynchronously mid-UNLOAD -> all outputs 0 immediately, before the next clock edge.
